array_row_arbiter: RTL



---
 rtl/array_row_arbiter.sv | 94 +++++++++
 1 files changed

// File: rtl/array_row_arbiter.sv
// array_row_arbiter: round-robin full-row write arbiter over a ROWS x COLS word array with clear sequencer and registered read.
// Optional macro ARRAY_RD_BYPASS_EN: same-cycle writes to rd_row are returned on rd_data (write-first).
module array_row_arbiter #(
  parameter int W       = 8,
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int NUM_REQ = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*$clog2(ROWS)-1:0] req_row,
  input  logic [NUM_REQ*COLS*W-1:0]       req_data,
  input  logic                            clr_start,
  output logic                            clr_busy,
  input  logic [$clog2(ROWS)-1:0]         rd_row,
  output logic [COLS*W-1:0]               rd_data,
  output logic [15:0]                     wr_count
);
  localparam int RW = $clog2(ROWS);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t              state_q, state_d;
  logic [W-1:0]        mem_q [ROWS][COLS];
  logic [RW-1:0]       clr_idx_q, clr_idx_d, wr_row;
  logic [PW-1:0]       ptr_q, ptr_d, gnt_idx;
  logic                gnt_found, accept, clr_we;
  logic [COLS*W-1:0]   wr_data, rd_data_q, rd_data_d;
  logic [15:0]         wr_count_q, wr_count_d;

  // first valid requester at or above the pointer, wrapping
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (!gnt_found && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'((int'(ptr_q) + k) % NUM_REQ);
      end
  end

  always_comb begin
    state_d   = state_q == IDLE ? (clr_start ? CLEAR : IDLE)
                                : (clr_idx_q == RW'(ROWS-1) ? IDLE : CLEAR);
    clr_idx_d = state_q == CLEAR ? clr_idx_q + 1'b1 : '0;
  end

  always_comb begin
    clr_busy  = state_q == CLEAR;
    req_ready = (!rst && state_q == IDLE && !clr_start && gnt_found) ? NUM_REQ'(1) << gnt_idx : '0;
  end

  assign accept     = |(req_valid & req_ready);
  assign clr_we     = state_q == CLEAR;
  assign wr_row     = req_row[gnt_idx*RW +: RW];
  assign wr_data    = req_data[gnt_idx*COLS*W +: COLS*W];
  assign ptr_d      = accept ? (gnt_idx == PW'(NUM_REQ-1) ? '0 : gnt_idx + 1'b1) : ptr_q;
  assign wr_count_d = (accept && wr_count_q != 16'hFFFF) ? wr_count_q + 16'd1 : wr_count_q;

  always_comb begin
    rd_data_d = '0;
    for (int c = 0; c < COLS; c++) rd_data_d[c*W +: W] = mem_q[rd_row][c];
`ifdef ARRAY_RD_BYPASS_EN
    if (clr_we && clr_idx_q == rd_row) rd_data_d = '0;
    else if (accept && wr_row == rd_row) rd_data_d = wr_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      clr_idx_q  <= '0;
      ptr_q      <= '0;
      wr_count_q <= '0;
      rd_data_q  <= '0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) mem_q[r][c] <= '0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      ptr_q      <= ptr_d;
      wr_count_q <= wr_count_d;
      rd_data_q  <= rd_data_d;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (clr_we && clr_idx_q == RW'(r)) mem_q[r][c] <= '0;
          else if (accept && wr_row == RW'(r)) mem_q[r][c] <= wr_data[c*W +: W];
    end
  end

  assign rd_data  = rd_data_q;
  assign wr_count = wr_count_q;
endmodule
